// File: rtl/hwjsoc_cpu_dct_packer_if.sv
// Valid/ready bus between the DCT packer, the trace tap and the trace FIFO.
// The master drives codes and consumes words; the slave is the packer.
interface hwjsoc_cpu_dct_packer_if #(
    parameter int BUF_W = 30,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [1:0]       in_code;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, dct_buffer, dct_count
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, dct_buffer, dct_count
    );
endinterface

// File: rtl/hwjsoc_cpu_dct_packer.sv
// Packs 2-bit branch trace codes into 15-entry words for the DCT trace FIFO.
// A full or flushed accumulator waits in PENDING while the output slot is busy.
module hwjsoc_cpu_dct_packer #(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    output logic overflow,
    hwjsoc_cpu_dct_packer_if.slave bus
);
    localparam int BUF_W = ENTRY_W * DEPTH;

    typedef enum logic {ACCUM, PENDING} state_t;

    state_t           state, state_nx;
    logic [BUF_W-1:0] acc, acc_nx, acc_in;
    logic [CNT_W-1:0] acc_cnt, cnt_nx, cnt_in;
    logic [BUF_W-1:0] buf_q, buf_nx;
    logic [CNT_W-1:0] count_q, count_nx;
    logic             valid_q, valid_nx;
    logic             ovf_q, ovf_nx;
    logic             accept, slot_free, trigger, load;

    assign bus.in_ready   = (state == ACCUM);
    assign bus.out_valid  = valid_q;
    assign bus.dct_buffer = buf_q;
    assign bus.dct_count  = count_q;
    assign overflow       = ovf_q;

    // Packing datapath, transfer decision and next-state logic.
    always_comb begin
        accept    = bus.in_valid & (state == ACCUM);
        acc_in    = accept ? {acc[BUF_W-ENTRY_W-1:0], bus.in_code} : acc;
        cnt_in    = acc_cnt + CNT_W'(accept);
        slot_free = !valid_q | bus.out_ready;
        trigger   = (cnt_in == CNT_W'(DEPTH)) | (flush & (cnt_in != '0));
        state_nx  = state;
        acc_nx    = acc_in;
        cnt_nx    = cnt_in;
        buf_nx    = buf_q;
        count_nx  = count_q;
        valid_nx  = valid_q & !bus.out_ready;
        ovf_nx    = ovf_q;
        load      = 1'b0;
        unique case (state)
            ACCUM: begin
                if (trigger) begin
                    if (slot_free) load = 1'b1;
                    else           state_nx = PENDING;
                end
            end
            PENDING: begin
                if (flush) ovf_nx = 1'b1;
                if (slot_free) begin
                    load     = 1'b1;
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
        if (load) begin
            buf_nx   = acc_in;
            count_nx = cnt_in;
            valid_nx = 1'b1;
            acc_nx   = '0;
            cnt_nx   = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ACCUM;
        else          state <= state_nx;
    end

    // Accumulator, output word and sticky overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            acc_cnt <= '0;
            buf_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc     <= acc_nx;
            acc_cnt <= cnt_nx;
            buf_q   <= buf_nx;
            count_q <= count_nx;
            valid_q <= valid_nx;
            ovf_q   <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_hwjsoc_cpu_dct_packer.sv
// Directed self-checking bench for the DCT packer.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_hwjsoc_cpu_dct_packer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic overflow;
    int   checks = 0;
    int   errors = 0;

    hwjsoc_cpu_dct_packer_if bus ();

    hwjsoc_cpu_dct_packer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .overflow (overflow),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [29:0] b,
                              input logic [3:0] c);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_buf"}, 32'(bus.dct_buffer), 32'(b));
        chk({name, "_cnt"}, 32'(bus.dct_count), 32'(c));
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_code   = 2'b00;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
        reset_n       = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_buf", 32'(bus.dct_buffer), 32'd0);
        chk("rst_cnt", 32'(bus.dct_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
    endtask

    task automatic test_full_word();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_code   = 2'b01;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 13) chk("full_early", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        check_word("full", 30'h15555555, 4'd15);
        step();
        chk("full_pop", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic test_flush();
        logic [1:0] codes [3];
        codes[0] = 2'b01;
        codes[1] = 2'b10;
        codes[2] = 2'b11;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_code = codes[i];
            step();
        end
        chk("flush_early", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        check_word("flush", 30'h0000001B, 4'd3);
        step();
        chk("flush_empty", 32'(bus.out_valid), 32'd0);
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.in_code = (i < 15) ? 2'b01 : 2'b10;
            step();
            if (i == 14) check_word("b2b_first", 30'h15555555, 4'd15);
            if (i == 21) check_word("b2b_hold", 30'h15555555, 4'd15);
            if (i == 28) chk("b2b_rdy_29", 32'(bus.in_ready), 32'd1);
        end
        chk("b2b_rdy_30", 32'(bus.in_ready), 32'd0);
        check_word("b2b_stall", 30'h15555555, 4'd15);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_word("b2b_second", 30'h2AAAAAAA, 4'd15);
        chk("b2b_rdy_back", 32'(bus.in_ready), 32'd1);
        step();
        chk("b2b_pop", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic test_code_and_flush();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_code   = 2'b01;
        for (int i = 0; i < 4; i++) step();
        bus.in_code = 2'b10;
        flush = 1'b1;
        step();
        check_word("cf", 30'h00000156, 4'd5);
        bus.in_valid = 1'b0;
        flush = 1'b0;
        step();
        chk("cf_pop", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 2'b11;
        step();
        step();
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        check_word("ovf_a", 30'h0000000F, 4'd2);
        flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code  = 2'b01;
        step();
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        chk("ovf_pend_rdy", 32'(bus.in_ready), 32'd0);
        chk("ovf_pre", 32'(overflow), 32'd0);
        step();
        chk("ovf_set", 32'(overflow), 32'd1);
        check_word("ovf_a_hold", 30'h0000000F, 4'd2);
        flush = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_word("ovf_b", 30'h00000001, 4'd1);
        chk("ovf_rdy", 32'(bus.in_ready), 32'd1);
        step();
        chk("ovf_no_extra", 32'(bus.out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 2'b10;
        flush = 1'b1;
        step();
        check_word("ar_word", 30'h00000002, 4'd1);
        flush = 1'b0;
        bus.in_code = 2'b01;
        for (int i = 0; i < 7; i++) step();
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_cnt", 32'(bus.dct_count), 32'd0);
        chk("ar_rdy", 32'(bus.in_ready), 32'd1);
        step();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        chk("ar_stale1", 32'(bus.out_valid), 32'd0);
        flush = 1'b0;
        step();
        chk("ar_stale2", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_code  = 2'b01;
        flush = 1'b1;
        step();
        check_word("ar_fresh", 30'h00000001, 4'd1);
        bus.in_valid = 1'b0;
        flush = 1'b0;
        step();
        chk("ar_pop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_back_to_back();
        test_code_and_flush();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
